// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised register file and its scoreboard.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_READ   = 2;

  // Index of the register that can be hard-wired to zero.
  localparam int ZERO_IDX = 0;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register plus a registered count of busy registers.
// A reserve marks a register busy and beats a same-edge write, since the newer
// producer supersedes the one that is writing back.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic                    ctrl_reserveEnable,
  input  logic [ADDR_WIDTH-1:0]   ctrl_reserveReg,
  input  logic                    ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]   ctrl_writeReg,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic [ADDR_WIDTH:0]     pending_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_WIDTH:0] count_next;

  // Next busy vector (write clears, reserve sets last so it wins) and its popcount.
  always_comb begin
    busy_next = busy;
    if (ctrl_writeEnable) busy_next[ctrl_writeReg] = 1'b0;
    if (ctrl_reserveEnable) busy_next[ctrl_reserveReg] = 1'b1;
    if (ZERO_REG != 0) busy_next[ZERO_IDX] = 1'b0;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
    end
  end

  // Busy state and count; reset discards every outstanding reservation.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      busy          <= '0;
      pending_count <= '0;
    end else begin
      busy          <= busy_next;
      pending_count <= count_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with combinational read ports, one synchronous
// write port, optional zero register, optional write-to-read bypass and a
// per-register busy scoreboard for issue logic.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clock,
  input  logic                           ctrl_reset,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            busy_readReg,
  input  logic                           ctrl_reserveEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
  output logic [ADDR_WIDTH:0]            pending_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  write_dropped;

  assign write_dropped = (ZERO_REG != 0) && (ctrl_writeReg == ADDR_WIDTH'(ZERO_IDX));

  // Storage array: reset clears every register, writes to a hard-wired r0 vanish.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (ctrl_writeEnable && !write_dropped) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clock              (clock),
    .ctrl_reset         (ctrl_reset),
    .ctrl_reserveEnable (ctrl_reserveEnable),
    .ctrl_reserveReg    (ctrl_reserveReg),
    .ctrl_writeEnable   (ctrl_writeEnable),
    .ctrl_writeReg      (ctrl_writeReg),
    .busy               (busy),
    .pending_count      (pending_count)
  );

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_zero;
    logic                  write_hit;
    logic                  reserve_hit;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rbusy;

    assign addr        = ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero     = (ZERO_REG != 0) && (addr == ADDR_WIDTH'(ZERO_IDX));
    assign write_hit   = (BYPASS != 0) && ctrl_writeEnable && (ctrl_writeReg == addr);
    assign reserve_hit = ctrl_reserveEnable && (ctrl_reserveReg == addr);

    // Read mux: zero register first, then the in-flight write, then storage.
    // A pending write clears busy early unless a new reserve targets the same register.
    always_comb begin
      rdata = regs[addr];
      rbusy = busy[addr];
      if (is_zero) begin
        rdata = '0;
        rbusy = 1'b0;
      end else if (write_hit) begin
        rdata = data_writeReg;
        if (!reserve_hit) rbusy = 1'b0;
      end
    end

    assign data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = rdata;
    assign busy_readReg[p] = rbusy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench: a default instance (A, bypass on) and a small
// four-port instance (B, 8 registers, bypass off) share clock and reset.
module tb_regfile_sb;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b0;

  always #5 clock = ~clock;

  // Instance A: DATA_WIDTH 32, ADDR_WIDTH 5, NUM_READ 2, ZERO_REG 1, BYPASS 1
  logic        a_we;
  logic [4:0]  a_wr;
  logic [31:0] a_wd;
  logic [9:0]  a_rd;
  logic [63:0] a_rdata;
  logic [1:0]  a_busy;
  logic        a_rsv_en;
  logic [4:0]  a_rsv;
  logic [5:0]  a_cnt;

  // Instance B: DATA_WIDTH 32, ADDR_WIDTH 3, NUM_READ 4, ZERO_REG 1, BYPASS 0
  logic         b_we;
  logic [2:0]   b_wr;
  logic [31:0]  b_wd;
  logic [11:0]  b_rd;
  logic [127:0] b_rdata;
  logic [3:0]   b_busy;
  logic         b_rsv_en;
  logic [2:0]   b_rsv;
  logic [3:0]   b_cnt;

  int checks = 0;
  int fails  = 0;

  regfile_sb #(
    .DATA_WIDTH (32), .ADDR_WIDTH (5), .NUM_READ (2), .ZERO_REG (1), .BYPASS (1)
  ) dut_a (
    .clock              (clock),
    .ctrl_reset         (ctrl_reset),
    .ctrl_writeEnable   (a_we),
    .ctrl_writeReg      (a_wr),
    .data_writeReg      (a_wd),
    .ctrl_readReg       (a_rd),
    .data_readReg       (a_rdata),
    .busy_readReg       (a_busy),
    .ctrl_reserveEnable (a_rsv_en),
    .ctrl_reserveReg    (a_rsv),
    .pending_count      (a_cnt)
  );

  regfile_sb #(
    .DATA_WIDTH (32), .ADDR_WIDTH (3), .NUM_READ (4), .ZERO_REG (1), .BYPASS (0)
  ) dut_b (
    .clock              (clock),
    .ctrl_reset         (ctrl_reset),
    .ctrl_writeEnable   (b_we),
    .ctrl_writeReg      (b_wr),
    .data_writeReg      (b_wd),
    .ctrl_readReg       (b_rd),
    .data_readReg       (b_rdata),
    .busy_readReg       (b_busy),
    .ctrl_reserveEnable (b_rsv_en),
    .ctrl_reserveReg    (b_rsv),
    .pending_count      (b_cnt)
  );

  // Let the staged inputs take effect at the next rising edge, then settle.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  // One comparison: counts it, and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    a_we = 0; a_wr = '0; a_wd = '0; a_rd = '0; a_rsv_en = 0; a_rsv = '0;
    b_we = 0; b_wr = '0; b_wd = '0; b_rd = '0; b_rsv_en = 0; b_rsv = '0;

    // Initial reset
    ctrl_reset = 1;
    applyStimulus();
    ctrl_reset = 0;

    // Preload r5, then reset with a simultaneous write of r7
    a_we = 1; a_wr = 5'd5; a_wd = 32'hDEADBEEF;
    applyStimulus();
    a_we = 0;
    a_rd = {5'd7, 5'd5};
    #1;
    checkOutput("preload_r5", a_rdata[31:0], 32'hDEADBEEF);
    ctrl_reset = 1;
    a_we = 1; a_wr = 5'd7; a_wd = 32'h1;
    applyStimulus();
    ctrl_reset = 0;
    a_we = 0;
    #1;
    checkOutput("reset_r5", a_rdata[31:0], 32'h0);
    checkOutput("reset_r7", a_rdata[63:32], 32'h0);
    checkOutput("reset_busy_a", a_busy, 2'b00);
    checkOutput("reset_cnt_a", a_cnt, 6'd0);
    b_rd = {3'd3, 3'd2, 3'd1, 3'd7};
    #1;
    checkOutput("reset_data_b", b_rdata, 128'h0);
    checkOutput("reset_busy_b", b_busy, 4'b0000);
    checkOutput("reset_cnt_b", b_cnt, 4'd0);

    // Zero register: write and reserve r0 together
    a_rd = {5'd0, 5'd0};
    a_we = 1; a_wr = 5'd0; a_wd = 32'hFFFFFFFF;
    a_rsv_en = 1; a_rsv = 5'd0;
    #1;
    checkOutput("zero_bypass_data", a_rdata[31:0], 32'h0);
    applyStimulus();
    a_we = 0; a_rsv_en = 0;
    #1;
    checkOutput("zero_data", a_rdata[31:0], 32'h0);
    checkOutput("zero_busy", a_busy, 2'b00);
    checkOutput("zero_cnt", a_cnt, 6'd0);

    // Bypass on (A) versus off (B): stored 0x11, same-cycle write 0x22 on port1
    a_we = 1; a_wr = 5'd3; a_wd = 32'h11;
    b_we = 1; b_wr = 3'd3; b_wd = 32'h11;
    applyStimulus();
    a_wd = 32'h22; b_wd = 32'h22;
    a_rd = {5'd3, 5'd0};
    b_rd = {3'd0, 3'd0, 3'd3, 3'd0};
    #1;
    checkOutput("bypass_on_before", a_rdata[63:32], 32'h22);
    checkOutput("bypass_off_before", b_rdata[63:32], 32'h11);
    applyStimulus();
    a_we = 0; b_we = 0;
    #1;
    checkOutput("bypass_on_after", a_rdata[63:32], 32'h22);
    checkOutput("bypass_off_after", b_rdata[63:32], 32'h22);

    // Reserve r9: not visible until after the edge
    a_rd = {5'd0, 5'd9};
    a_rsv_en = 1; a_rsv = 5'd9;
    #1;
    checkOutput("reserve_no_bypass", a_busy[0], 1'b0);
    applyStimulus();
    a_rsv_en = 0;
    #1;
    checkOutput("reserve_busy", a_busy[0], 1'b1);
    checkOutput("reserve_cnt", a_cnt, 6'd1);

    // Write r9 clears busy; bypass already clears it before the edge
    a_we = 1; a_wr = 5'd9; a_wd = 32'h55;
    #1;
    checkOutput("write_busy_bypass", a_busy[0], 1'b0);
    checkOutput("write_data_bypass", a_rdata[31:0], 32'h55);
    applyStimulus();
    a_we = 0;
    #1;
    checkOutput("write_busy", a_busy[0], 1'b0);
    checkOutput("write_cnt", a_cnt, 6'd0);

    // Reserve and write r9 at the same edge: reserve wins
    a_we = 1; a_wr = 5'd9; a_wd = 32'h66;
    a_rsv_en = 1; a_rsv = 5'd9;
    applyStimulus();
    #1;
    checkOutput("rsv_wr_busy_hold", a_busy[0], 1'b1);
    checkOutput("rsv_wr_cnt", a_cnt, 6'd1);
    applyStimulus();
    a_we = 0; a_rsv_en = 0;
    #1;
    checkOutput("rsv_again_busy", a_busy[0], 1'b1);
    checkOutput("rsv_again_cnt", a_cnt, 6'd1);
    checkOutput("rsv_wr_data", a_rdata[31:0], 32'h66);

    // Count saturation on B: reserve r1..r7, re-reserve r4, then write r2 and r1
    for (int i = 1; i <= 7; i++) begin
      b_rsv_en = 1; b_rsv = 3'(i);
      applyStimulus();
      checkOutput("sat_cnt_step", b_cnt, 128'(i));
    end
    b_rsv = 3'd4;
    applyStimulus();
    b_rsv_en = 0;
    checkOutput("sat_rereserve", b_cnt, 4'd7);
    b_we = 1; b_wr = 3'd2; b_wd = 32'hB;
    applyStimulus();
    checkOutput("sat_write_r2", b_cnt, 4'd6);
    b_wr = 3'd1; b_wd = 32'hA;
    applyStimulus();
    b_we = 0;
    checkOutput("sat_write_r1", b_cnt, 4'd5);

    // Multi-port read: ports read r1, r2, r0, r1
    b_rd = {3'd1, 3'd0, 3'd2, 3'd1};
    #1;
    checkOutput("multi_data", b_rdata, {32'hA, 32'h0, 32'hB, 32'hA});
    checkOutput("multi_busy", b_busy, 4'b0000);
    b_rd = {3'd1, 3'd5, 3'd2, 3'd1};
    #1;
    checkOutput("multi_busy_r5", b_busy, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
